// File: rtl/dkm_multi.sv
// dkm_multi: multi-channel drink vending controller.
// CHANNELS can slots share one credit register and one nickel/dime change bank.
// Credit is kept in nickel units; a vend pays at most 20c of change.
// Optional feature macro: DKM_COIN_RECYCLE_EN. When it is defined, accepted
// nickels and dimes are also added to the change inventory.
module dkm_multi #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int PRICE    = 50,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_coins,
    input  logic                load_cans,
    input  logic [SEL_W-1:0]    load_sel,
    input  logic [CNT_W-1:0]    nickels,
    input  logic [CNT_W-1:0]    dimes,
    input  logic [CNT_W-1:0]    cans,
    input  logic                nickel_in,
    input  logic                dime_in,
    input  logic                quarter_in,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel,
    output logic [CHANNELS-1:0] empty,
    output logic                dispense,
    output logic [SEL_W-1:0]    dispense_ch,
    output logic                nickel_out,
    output logic                dime_out,
    output logic                two_dime_out,
    output logic                use_exact,
    output logic                coin_return
);

    localparam int PRICE_N = PRICE / 5;
    // Credit can overshoot the price by at most four nickels (one quarter late).
    localparam int CR_W = $clog2(PRICE_N + 5) + 1;
    localparam logic [CR_W-1:0] PRICE_C = CR_W'(PRICE_N);
    localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2
    } state_t;

    state_t            state_q, state_nx;
    logic [CNT_W-1:0]  cans_q [CHANNELS];
    logic [CNT_W-1:0]  nickels_q, dimes_q;
    logic [CR_W-1:0]   credit_q, credit_nx;
    logic              sel_vld_q, sel_vld_nx;
    logic [SEL_W-1:0]  sel_q, sel_nx;

    logic [1:0]        coin_cnt;
    logic              any_coin, reject, accept;
    logic [CR_W-1:0]   coin_val, credit_add, chg;
    logic              sel_ok, sel_has_can, vend_go;
    logic              pay_nickel, pay_dime, pay_two;
    logic              nick_rcy, dime_rcy;
    logic [CNT_W:0]    nick_add, dime_add;
    logic [1:0]        nick_dec, dime_dec;

    // Saturating inventory update: old + add - dec, clamped at all-ones.
    // Callers only request a decrement when the stock is there to cover it.
    function automatic logic [CNT_W-1:0] sat_upd(input logic [CNT_W-1:0] old,
                                                 input logic [CNT_W:0]   add,
                                                 input logic [1:0]       dec);
        logic [CNT_W+1:0] s;
        s = {2'b00, old} + {1'b0, add} - {{CNT_W{1'b0}}, dec};
        return (s > CNT_MAX) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Channel empty flags and exact-change indication come straight from registered counts.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            empty[i] = (cans_q[i] == '0);
        end
        use_exact = !((nickels_q != '0) && (dimes_q >= CNT_W'(2)));
    end

    // Coin acceptance, vend decision and change selection.
    always_comb begin
        coin_cnt = {1'b0, nickel_in} + {1'b0, dime_in} + {1'b0, quarter_in};
        any_coin = (coin_cnt != 2'd0);
        coin_val = '0;
        if (nickel_in)       coin_val = CR_W'(1);
        else if (dime_in)    coin_val = CR_W'(2);
        else if (quarter_in) coin_val = CR_W'(5);
        credit_add = credit_q + coin_val;

        sel_has_can = sel_vld_q && !empty[sel_q];
        vend_go     = (state_q == S_COLLECT) && (credit_q >= PRICE_C) && sel_has_can;
        sel_ok      = sel_valid && (int'(sel) < CHANNELS) && !empty[sel];

        // Credit at or above price means a vend is due or a selection is awaited.
        reject = any_coin && ((coin_cnt > 2'd1) || (state_q == S_VEND) ||
                              (credit_q >= PRICE_C) ||
                              (use_exact && (credit_add > PRICE_C)));
        accept = any_coin && !reject;

        chg        = credit_q - PRICE_C;
        pay_nickel = vend_go && ((chg == CR_W'(1)) || (chg == CR_W'(3))) && (nickels_q != '0);
        pay_dime   = vend_go && ((chg == CR_W'(2)) || (chg == CR_W'(3))) && (dimes_q != '0);
        pay_two    = vend_go && (chg == CR_W'(4)) && (dimes_q >= CNT_W'(2));
        nick_dec   = pay_nickel ? 2'd1 : 2'd0;
        dime_dec   = pay_two ? 2'd2 : (pay_dime ? 2'd1 : 2'd0);
    end

`ifdef DKM_COIN_RECYCLE_EN
    assign nick_rcy = accept && nickel_in;
    assign dime_rcy = accept && dime_in;
`else
    assign nick_rcy = 1'b0;
    assign dime_rcy = 1'b0;
`endif

    assign nick_add = (load_coins ? {1'b0, nickels} : '0) + {{CNT_W{1'b0}}, nick_rcy};
    assign dime_add = (load_coins ? {1'b0, dimes}   : '0) + {{CNT_W{1'b0}}, dime_rcy};

    // Next credit, next selection and next FSM state.
    always_comb begin
        credit_nx  = credit_q;
        sel_vld_nx = sel_vld_q;
        sel_nx     = sel_q;
        state_nx   = state_q;
        if (vend_go) begin
            credit_nx  = '0;
            sel_vld_nx = 1'b0;
        end else begin
            if (accept) credit_nx = credit_add;
            if (sel_ok) begin
                sel_vld_nx = 1'b1;
                sel_nx     = sel;
            end
        end
        case (state_q)
            S_IDLE: begin
                if ((credit_nx != '0) || sel_vld_nx) state_nx = S_COLLECT;
            end
            S_COLLECT: begin
                if (vend_go)                                 state_nx = S_VEND;
                else if ((credit_nx == '0) && !sel_vld_nx)   state_nx = S_IDLE;
            end
            S_VEND:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM, credit and selection registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            credit_q  <= '0;
            sel_vld_q <= 1'b0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_nx;
            credit_q  <= credit_nx;
            sel_vld_q <= sel_vld_nx;
            sel_q     <= sel_nx;
        end
    end

    // Can and change inventories: loads, recycling and vend payouts in one update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nickels_q <= '0;
            dimes_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) cans_q[i] <= '0;
        end else begin
            nickels_q <= sat_upd(nickels_q, nick_add, nick_dec);
            dimes_q   <= sat_upd(dimes_q, dime_add, dime_dec);
            for (int i = 0; i < CHANNELS; i++) begin
                cans_q[i] <= sat_upd(cans_q[i],
                                     (load_cans && (load_sel == SEL_W'(i))) ? {1'b0, cans} : '0,
                                     (vend_go && (sel_q == SEL_W'(i))) ? 2'd1 : 2'd0);
            end
        end
    end

    // Registered vend and coin-return pulses, valid the cycle after the deciding edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dispense     <= 1'b0;
            dispense_ch  <= '0;
            nickel_out   <= 1'b0;
            dime_out     <= 1'b0;
            two_dime_out <= 1'b0;
            coin_return  <= 1'b0;
        end else begin
            dispense     <= vend_go;
            if (vend_go) dispense_ch <= sel_q;
            nickel_out   <= pay_nickel;
            dime_out     <= pay_dime;
            two_dime_out <= pay_two;
            coin_return  <= reject;
        end
    end

endmodule

// File: tb/tb_dkm_multi.sv
// tb_dkm_multi: directed bench for dkm_multi (CHANNELS=4, CNT_W=8, PRICE=50).
// Expected vends are queued when a purchase is set up and checked when DISPENSE fires.
module tb_dkm_multi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_coins = 1'b0, load_cans = 1'b0;
    logic [1:0] load_sel = '0;
    logic [7:0] nickels = '0, dimes = '0, cans = '0;
    logic       nickel_in = 1'b0, dime_in = 1'b0, quarter_in = 1'b0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel = '0;
    logic [3:0] empty;
    logic       dispense;
    logic [1:0] dispense_ch;
    logic       nickel_out, dime_out, two_dime_out, use_exact, coin_return;

    typedef struct packed {
        logic [1:0] ch;
        logic       n;
        logic       d;
        logic       t;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   vend_seen = 0;

    dkm_multi #(.CHANNELS(4), .CNT_W(8), .PRICE(50)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_coins(load_coins), .load_cans(load_cans), .load_sel(load_sel),
        .nickels(nickels), .dimes(dimes), .cans(cans),
        .nickel_in(nickel_in), .dime_in(dime_in), .quarter_in(quarter_in),
        .sel_valid(sel_valid), .sel(sel),
        .empty(empty), .dispense(dispense), .dispense_ch(dispense_ch),
        .nickel_out(nickel_out), .dime_out(dime_out), .two_dime_out(two_dime_out),
        .use_exact(use_exact), .coin_return(coin_return)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every DISPENSE must match the oldest queued purchase.
    always @(negedge clk) begin
        if (rst_n && dispense) begin
            vend_seen++;
            check("vend_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("dispense_ch", 32'(dispense_ch), 32'(e.ch));
                check("change", {29'd0, nickel_out, dime_out, two_dime_out}, {29'd0, e.n, e.d, e.t});
            end
        end else if (rst_n) begin
            check("stray_change", {29'd0, nickel_out, dime_out, two_dime_out}, 32'd0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_empty", 32'(empty), 32'hF);
        check("rst_use_exact", 32'(use_exact), 32'd1);
        check("rst_pulses", {27'd0, dispense, nickel_out, dime_out, two_dime_out, coin_return}, 32'd0);
        check("rst_dispense_ch", 32'(dispense_ch), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic load(input logic lc, input logic lk, input logic [1:0] ls,
                        input logic [7:0] n, input logic [7:0] d, input logic [7:0] c);
        @(negedge clk);
        load_coins = lc; load_cans = lk; load_sel = ls;
        nickels = n; dimes = d; cans = c;
        @(negedge clk);
        load_coins = 1'b0; load_cans = 1'b0;
    endtask

    task automatic select(input logic [1:0] s);
        @(negedge clk);
        sel_valid = 1'b1; sel = s;
        @(negedge clk);
        sel_valid = 1'b0;
    endtask

    task automatic coin(input logic n, input logic d, input logic q,
                        input logic exp_ret, input string tag);
        @(negedge clk);
        nickel_in = n; dime_in = d; quarter_in = q;
        @(negedge clk);
        nickel_in = 1'b0; dime_in = 1'b0; quarter_in = 1'b0;
        check(tag, 32'(coin_return), 32'(exp_ret));
    endtask

    task automatic wait_vend(input int start);
        for (int i = 0; i < 12; i++) begin
            if (vend_seen > start) break;
            @(negedge clk);
        end
        check("vend_seen", vend_seen, start + 1);
        @(negedge clk);
    endtask

    initial begin
        int v;
        do_reset();

        // Two quarters, no change bank: exact 50c vend from channel 2.
        load(1'b0, 1'b1, 2'd2, 8'd0, 8'd0, 8'd1);
        check("empty_after_load2", 32'(empty), 32'hB);
        select(2'd2);
        sb.push_back('{ch: 2'd2, n: 1'b0, d: 1'b0, t: 1'b0});
        v = vend_seen;
        coin(1'b0, 1'b0, 1'b1, 1'b0, "s1_q1");
        coin(1'b0, 1'b0, 1'b1, 1'b0, "s1_q2");
        wait_vend(v);
        check("empty_after_vend2", 32'(empty), 32'hF);

        // 55c with one nickel and two dimes loaded: nickel change, bank then short of nickels.
        load(1'b1, 1'b1, 2'd0, 8'd1, 8'd2, 8'd1);
        check("use_exact_loaded", 32'(use_exact), 32'd0);
        check("empty_after_load0", 32'(empty), 32'hE);
        select(2'd0);
        sb.push_back('{ch: 2'd0, n: 1'b1, d: 1'b0, t: 1'b0});
        v = vend_seen;
        coin(1'b0, 1'b1, 1'b0, 1'b0, "s2_d1");
        coin(1'b0, 1'b1, 1'b0, 1'b0, "s2_d2");
        coin(1'b0, 1'b1, 1'b0, 1'b0, "s2_d3");
        coin(1'b0, 1'b0, 1'b1, 1'b0, "s2_q");
        wait_vend(v);
        check("use_exact_after_nickel", 32'(use_exact), 32'd1);

        // 65c: 15c change as nickel plus dime.
        load(1'b1, 1'b1, 2'd1, 8'd2, 8'd3, 8'd1);
        select(2'd1);
        sb.push_back('{ch: 2'd1, n: 1'b1, d: 1'b1, t: 1'b0});
        v = vend_seen;
        coin(1'b1, 1'b0, 1'b0, 1'b0, "s3_n");
        coin(1'b0, 1'b1, 1'b0, 1'b0, "s3_d");
        coin(1'b0, 1'b0, 1'b1, 1'b0, "s3_q1");
        coin(1'b0, 1'b0, 1'b1, 1'b0, "s3_q2");
        wait_vend(v);
        check("use_exact_after_15", 32'(use_exact), 32'd0);

        // Selection of an empty channel is ignored; full credit without selection rejects coins.
        load(1'b0, 1'b1, 2'd3, 8'd0, 8'd0, 8'd1);
        select(2'd0);
        v = vend_seen;
        coin(1'b0, 1'b0, 1'b1, 1'b0, "s4_q1");
        coin(1'b0, 1'b0, 1'b1, 1'b0, "s4_q2");
        coin(1'b0, 1'b0, 1'b1, 1'b1, "s4_q_full");
        check("no_vend_without_sel", vend_seen, v);
        sb.push_back('{ch: 2'd3, n: 1'b0, d: 1'b0, t: 1'b0});
        select(2'd3);
        wait_vend(v);

        // Exact-change mode: overshooting quarter at 45c bounces, nickel then completes 50c.
        do_reset();
        load(1'b0, 1'b1, 2'd3, 8'd0, 8'd0, 8'd1);
        select(2'd3);
        v = vend_seen;
        coin(1'b0, 1'b0, 1'b1, 1'b0, "s5_q");
        coin(1'b0, 1'b1, 1'b0, 1'b0, "s5_d1");
        coin(1'b0, 1'b1, 1'b0, 1'b0, "s5_d2");
        coin(1'b0, 1'b0, 1'b1, 1'b1, "s5_q_over");
        check("no_vend_at_45", vend_seen, v);
        sb.push_back('{ch: 2'd3, n: 1'b0, d: 1'b0, t: 1'b0});
        coin(1'b1, 1'b0, 1'b0, 1'b0, "s5_n");
        wait_vend(v);

        // Two coins at once bounce and leave credit at zero.
        load(1'b0, 1'b1, 2'd1, 8'd0, 8'd0, 8'd1);
        select(2'd1);
        sb.push_back('{ch: 2'd1, n: 1'b0, d: 1'b0, t: 1'b0});
        v = vend_seen;
        coin(1'b0, 1'b1, 1'b1, 1'b1, "s6_dq");
        coin(1'b0, 1'b0, 1'b1, 1'b0, "s6_q1");
        coin(1'b0, 1'b0, 1'b1, 1'b0, "s6_q2");
        wait_vend(v);

        // A single accepted dime enters the bank only when recycling is built in.
        do_reset();
        load(1'b1, 1'b0, 2'd0, 8'd1, 8'd1, 8'd0);
        check("use_exact_one_dime", 32'(use_exact), 32'd1);
        coin(1'b0, 1'b1, 1'b0, 1'b0, "s7_d");
`ifdef DKM_COIN_RECYCLE_EN
        check("recycle_dime", 32'(use_exact), 32'd0);
`else
        check("recycle_dime", 32'(use_exact), 32'd1);
`endif
        load(1'b0, 1'b1, 2'd0, 8'd0, 8'd0, 8'd1);
        select(2'd0);
        sb.push_back('{ch: 2'd0, n: 1'b0, d: 1'b0, t: 1'b0});
        v = vend_seen;
        coin(1'b0, 1'b0, 1'b1, 1'b0, "s7_q");
        coin(1'b0, 1'b1, 1'b0, 1'b0, "s7_d2");
        coin(1'b1, 1'b0, 1'b0, 1'b0, "s7_n");
        wait_vend(v);
        check("empty_final", 32'(empty), 32'hF);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
